punc_mem_arbiter: RTL and testbench

- Shares the single PUnC memory port between two requesters:
  - the CPU: the control unit's fetch, LD/LDI/LDR/ST/STI/STR accesses;
  - a debug/program-loader port.
- Arbitration runs every cycle with fixed CPU priority.
- A burst limit prevents debug starvation, and a CPU lock keeps two-phase LDI/STI indirections atomic.
- Read data is registered and returned to the winner one cycle after its grant, with a valid pulse.

---
 rtl/punc_mem_arbiter.sv | 86 ++++++++
 tb/tb_punc_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: shares the PUnC memory port between the CPU and a debug loader
module punc_mem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_lock,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, CPU_OWN, DBG_OWN, CPU_LOCKED} state_t;
   localparam logic [3:0] BMAX = 4'(BURST_MAX);
   state_t     state, state_nxt;
   logic [3:0] burst_cnt, burst_nxt;
   // grant decision, memory mux, next owner and burst count; reset forces the idle mux at once
   always_comb begin
      cpu_gnt   = 1'b0;
      dbg_gnt   = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      state_nxt = IDLE;
      burst_nxt = burst_cnt;
      if (!rst) begin
         cpu_gnt = cpu_req && (state == CPU_LOCKED || !dbg_req || burst_cnt != BMAX);
         dbg_gnt = dbg_req && !cpu_gnt && state != CPU_LOCKED;
      end
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
         state_nxt = cpu_lock ? CPU_LOCKED : CPU_OWN;
      end else if (dbg_gnt) begin
         mem_addr  = dbg_addr;
         mem_we    = dbg_we;
         mem_wdata = dbg_wdata;
         state_nxt = DBG_OWN;
      end
      if (!dbg_req || dbg_gnt) burst_nxt = '0;
      else if (cpu_gnt && burst_cnt != BMAX) burst_nxt = burst_cnt + 4'd1;
   end
   assign cpu_stall = cpu_req && !cpu_gnt;
   // owner of the previous cycle and consecutive CPU wins against a waiting debug request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_nxt;
      end
   end
   // read data returns to the winner one cycle after its read grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
      end else begin
         cpu_rvalid <= cpu_gnt && !cpu_we;
         dbg_rvalid <= dbg_gnt && !dbg_we;
         if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
         if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_punc_mem_arbiter.sv
// tb_punc_mem_arbiter: directed and randomized checks of the CPU/debug memory arbiter
module tb_punc_mem_arbiter;
   localparam int BM = 4;
   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_lock, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic [15:0] mem    [0:65535];
   logic [15:0] shadow [0:65535];
   int          n_cmp = 0, n_bad = 0;
   int          m_wins;
   bit          m_locked;
   logic        e_cgnt, e_dgnt, e_crv, e_drv;
   logic [15:0] e_crd, e_drd;

   punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_MAX(BM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

   // reference: CPU has priority unless debug has waited through BM CPU wins; a lock pins the CPU
   task automatic predict();
      if (m_locked) begin
         e_cgnt = cpu_req;
         e_dgnt = 1'b0;
      end else if (cpu_req && dbg_req) begin
         e_dgnt = (m_wins == BM);
         e_cgnt = !e_dgnt;
      end else begin
         e_cgnt = cpu_req;
         e_dgnt = dbg_req;
      end
   endtask

   task automatic model_reset();
      m_wins = 0; m_locked = 0;
      e_crv = 0; e_drv = 0; e_crd = 0; e_drd = 0;
   endtask

   task automatic advance();
      predict();
      @(posedge clk);
      e_crv = e_cgnt && !cpu_we;
      e_drv = e_dgnt && !dbg_we;
      if (e_crv) e_crd = shadow[cpu_addr];
      if (e_drv) e_drd = shadow[dbg_addr];
      if (e_cgnt && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (e_dgnt && dbg_we) shadow[dbg_addr] = dbg_wdata;
      if (!dbg_req || e_dgnt) m_wins = 0;
      else if (e_cgnt && m_wins < BM) m_wins++;
      m_locked = e_cgnt && cpu_lock;
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_lock = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1111; cpu_wdata = 16'h2222;
      #3;
      n_cmp++;
      if ({mem_we, cpu_gnt, dbg_gnt} !== 3'b000) begin
         n_bad++; $display("FAIL reset_gnt: got we/cg/dg=%b required 000", {mem_we, cpu_gnt, dbg_gnt});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata} !== 32'h0) begin
         n_bad++; $display("FAIL reset_mux: got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
      end
      n_cmp++;
      if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata} !== 34'h0) begin
         n_bad++; $display("FAIL reset_rdata: got rv=%b%b rd=%h/%h required 0", cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 0; idle_inputs(); model_reset();
   endtask

   task automatic test_solo_read();
      mem[16'h3000] = 16'h1234; shadow[16'h3000] = 16'h1234;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, dbg_gnt, mem_we, mem_addr} !== {3'b100, 16'h3000}) begin
         n_bad++; $display("FAIL solo_grant: got cg/dg/we=%b%b%b addr=%h required 100 3000", cpu_gnt, dbg_gnt, mem_we, mem_addr);
      end
      advance();
      cpu_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h1234}) begin
         n_bad++; $display("FAIL solo_rdata: got rv=%b rd=%h required 1 1234", cpu_rvalid, cpu_rdata);
      end
      n_cmp++;
      if ({dbg_gnt, dbg_rvalid, dbg_rdata} !== 18'h0) begin
         n_bad++; $display("FAIL solo_dbg_quiet: got dg=%b rv=%b rd=%h required 0", dbg_gnt, dbg_rvalid, dbg_rdata);
      end
      advance();
      @(negedge clk);
      n_cmp++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b0, 16'h1234}) begin
         n_bad++; $display("FAIL solo_hold: got rv=%b rd=%h required 0 1234", cpu_rvalid, cpu_rdata);
      end
      advance();
   endtask

   task automatic test_dbg_only();
      cpu_req = 0;
      for (int i = 0; i < 4; i++) begin
         dbg_req = 1; dbg_we = 1; dbg_addr = 16'(i); dbg_wdata = 16'hA0A0 + 16'(i);
         @(negedge clk);
         n_cmp++;
         if ({dbg_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'(i), 16'hA0A0 + 16'(i)}) begin
            n_bad++; $display("FAIL dbg_write%0d: got gnt=%b we=%b addr=%h data=%h", i, dbg_gnt, mem_we, mem_addr, mem_wdata);
         end
         advance();
      end
      dbg_req = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (mem[i] !== 16'hA0A0 + 16'(i)) begin
            n_bad++; $display("FAIL dbg_mem%0d: got %h required %h", i, mem[i], 16'hA0A0 + 16'(i));
         end
      end
      n_cmp++;
      if (dbg_rvalid !== 1'b0) begin
         n_bad++; $display("FAIL dbg_write_rvalid: got %b required 0", dbg_rvalid);
      end
      advance();
   endtask

   task automatic test_burst();
      bit exp_d;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      dbg_req = 1; dbg_we = 1; dbg_addr = 16'h4000; dbg_wdata = 16'hBEEF;
      for (int i = 0; i < 10; i++) begin
         exp_d = (i == 4 || i == 9);
         @(negedge clk);
         n_cmp++;
         if ({cpu_gnt, dbg_gnt, cpu_stall} !== {!exp_d, exp_d, exp_d}) begin
            n_bad++; $display("FAIL burst_c%0d: got cg/dg/stall=%b%b%b required %b%b%b", i, cpu_gnt, dbg_gnt, cpu_stall, !exp_d, exp_d, exp_d);
         end
         n_cmp++;
         if (mem_addr !== (exp_d ? dbg_addr : 16'h3000)) begin
            n_bad++; $display("FAIL burst_addr%0d: got %h required %h", i, mem_addr, exp_d ? dbg_addr : 16'h3000);
         end
         advance();
         if (i == 4) begin dbg_addr = 16'h4001; dbg_wdata = 16'h0001; end
      end
      idle_inputs();
      @(negedge clk);
      n_cmp++;
      if ({mem[16'h4000], mem[16'h4001]} !== {16'hBEEF, 16'h0001}) begin
         n_bad++; $display("FAIL burst_mem: got %h %h required beef 0001", mem[16'h4000], mem[16'h4001]);
      end
      advance();
   endtask

   task automatic test_lock();
      logic [15:0] addrs [6];
      bit          exp_d;
      addrs = '{16'h3000, 16'h3000, 16'h3000, 16'h3005, 16'h5000, 16'h3000};
      mem[16'h3005] = 16'h5000; shadow[16'h3005] = 16'h5000;
      mem[16'h5000] = 16'h7777; shadow[16'h5000] = 16'h7777;
      dbg_req = 1; dbg_we = 1; dbg_addr = 16'h4100; dbg_wdata = 16'h1111;
      for (int i = 0; i < 6; i++) begin
         cpu_req = 1; cpu_we = 0; cpu_addr = addrs[i]; cpu_lock = (i == 3);
         exp_d = (i == 5);
         @(negedge clk);
         n_cmp++;
         if ({cpu_gnt, dbg_gnt, mem_addr} !== {!exp_d, exp_d, exp_d ? 16'h4100 : addrs[i]}) begin
            n_bad++; $display("FAIL lock_c%0d: got cg/dg=%b%b addr=%h", i, cpu_gnt, dbg_gnt, mem_addr);
         end
         if (i == 4 || i == 5) begin
            n_cmp++;
            if ({cpu_rvalid, cpu_rdata} !== {1'b1, i == 4 ? 16'h5000 : 16'h7777}) begin
               n_bad++; $display("FAIL lock_rdata%0d: got rv=%b rd=%h", i, cpu_rvalid, cpu_rdata);
            end
         end
         advance();
         if (i == 5) dbg_req = 0;
      end
      cpu_lock = 0;
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, mem_addr} !== {1'b1, 16'h3000}) begin
         n_bad++; $display("FAIL lock_resume: got cg=%b addr=%h required 1 3000", cpu_gnt, mem_addr);
      end
      advance();
      idle_inputs();
      advance();
   endtask

   task automatic test_async_reset();
      mem[16'h6000] = 16'h5555; shadow[16'h6000] = 16'h5555;
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h6000; cpu_wdata = 16'hAAAA;
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, mem_we} !== 2'b11) begin
         n_bad++; $display("FAIL areset_pre: got cg/we=%b%b required 11", cpu_gnt, mem_we);
      end
      #1 rst = 1;
      #1;
      n_cmp++;
      if ({cpu_gnt, mem_we, mem_addr, mem_wdata} !== 34'h0) begin
         n_bad++; $display("FAIL areset_mux: got cg=%b we=%b addr=%h data=%h required 0", cpu_gnt, mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (mem[16'h6000] !== 16'h5555) begin
         n_bad++; $display("FAIL areset_nowrite: got %h required 5555", mem[16'h6000]);
      end
      rst = 0; idle_inputs(); model_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      @(negedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      n_cmp++;
      if ({cpu_rvalid, cpu_rdata} !== 17'h0) begin
         n_bad++; $display("FAIL areset_rvalid: got rv=%b rd=%h required 0", cpu_rvalid, cpu_rdata);
      end
      rst = 0; idle_inputs(); model_reset();
      cpu_req = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({cpu_gnt, dbg_gnt} !== {i != 4, i == 4}) begin
            n_bad++; $display("FAIL areset_burst%0d: got cg/dg=%b%b required %b%b", i, cpu_gnt, dbg_gnt, i != 4, i == 4);
         end
         advance();
      end
      idle_inputs();
      advance();
   endtask

   task automatic test_random();
      bit c_done = 1, d_done = 1;
      for (int n = 0; n < 600; n++) begin
         if (c_done || !cpu_req) begin
            cpu_req = $urandom_range(0, 3) != 0; cpu_we = $urandom_range(0, 2) == 0;
            cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
            cpu_lock = $urandom_range(0, 3) == 0;
         end
         if (d_done || !dbg_req) begin
            dbg_req = $urandom_range(0, 1) != 0; dbg_we = $urandom_range(0, 1) == 0;
            dbg_addr = 16'($urandom_range(0, 15)); dbg_wdata = 16'($urandom);
         end
         @(negedge clk);
         predict();
         n_cmp++;
         if ({cpu_gnt, dbg_gnt, cpu_stall} !== {e_cgnt, e_dgnt, cpu_req && !e_cgnt}) begin
            n_bad++; $display("FAIL rnd_gnt@%0d: got cg/dg/stall=%b%b%b required %b%b%b", n, cpu_gnt, dbg_gnt, cpu_stall, e_cgnt, e_dgnt, cpu_req && !e_cgnt);
         end
         n_cmp++;
         if ({mem_we, mem_addr, mem_wdata} !== (e_cgnt ? {cpu_we, cpu_addr, cpu_wdata} : e_dgnt ? {dbg_we, dbg_addr, dbg_wdata} : 33'h0)) begin
            n_bad++; $display("FAIL rnd_mux@%0d: got we=%b addr=%h data=%h", n, mem_we, mem_addr, mem_wdata);
         end
         n_cmp++;
         if ({cpu_rvalid, cpu_rdata} !== {e_crv, e_crd}) begin
            n_bad++; $display("FAIL rnd_cpu_rd@%0d: got %b %h required %b %h", n, cpu_rvalid, cpu_rdata, e_crv, e_crd);
         end
         n_cmp++;
         if ({dbg_rvalid, dbg_rdata} !== {e_drv, e_drd}) begin
            n_bad++; $display("FAIL rnd_dbg_rd@%0d: got %b %h required %b %h", n, dbg_rvalid, dbg_rdata, e_drv, e_drd);
         end
         advance();
         c_done = e_cgnt;
         d_done = e_dgnt;
      end
      idle_inputs();
      advance();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'(i * 7 + 3);
         shadow[i] = 16'(i * 7 + 3);
      end
      model_reset();
      test_reset();
      test_solo_read();
      test_dbg_only();
      test_burst();
      test_lock();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
